// File: rtl/r_exec_pkg.sv
// Shared definitions for the R-type decode/execute/write-back stage:
// instruction field positions, funct codes and FSM state encoding.
package r_exec_pkg;

   localparam int DATA_W   = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int RD_MSB = 15;
   localparam int RD_LSB = 11;
   localparam int SH_MSB = 10;
   localparam int SH_LSB = 6;
   localparam int FN_MSB = 5;
   localparam int FN_LSB = 0;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_WB     = 2'd3
   } state_t;

   function automatic logic funct_legal(input logic [5:0] fn);
      case (fn)
         F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
         F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
         F_XOR, F_NOR, F_SLT, F_SLTU: return 1'b1;
         default:                     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/r_exec_stage_regfile.sv
// 32x32 register file: two operand read ports, one debug read port and a
// single write port; $0 always reads zero and ignores writes.
module regfile
   import r_exec_pkg::*;
#(
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   input  logic [REG_AW-1:0] dbg_raddr,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   output logic [DATA_W-1:0] dbg_rdata
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   // With CLEAR_ON_RST=0 the array is pure storage and survives reset.
   always_ff @(posedge clk) begin
      if (rst && CLEAR_ON_RST) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a   = (raddr_a   == '0) ? '0 : mem[raddr_a];
   assign rdata_b   = (raddr_b   == '0) ? '0 : mem[raddr_b];
   assign dbg_rdata = (dbg_raddr == '0) ? '0 : mem[dbg_raddr];

endmodule

// File: rtl/r_exec_stage.sv
// R-type decode/execute/write-back stage: one instruction every four cycles
// through IDLE -> DECODE -> EXEC -> WB, with an internal register file.
module r_exec_stage
   import r_exec_pkg::*;
#(
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       inst_code,
   input  logic              inst_valid,
   output logic              inst_ready,
   input  logic              dbg_we,
   input  logic [REG_AW-1:0] dbg_waddr,
   input  logic [DATA_W-1:0] dbg_wdata,
   input  logic [REG_AW-1:0] dbg_raddr,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              wb_en,
   output logic [REG_AW-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              zf,
   output logic              of,
   output logic              illegal,
   output logic [15:0]       retired
);

   state_t            state;
   state_t            state_next;
   logic [31:0]       inst_p0;
   logic [DATA_W-1:0] op_a_p1;
   logic [DATA_W-1:0] op_b_p1;
   logic [DATA_W-1:0] rf_rdata_a;
   logic [DATA_W-1:0] rf_rdata_b;
   logic              rf_we;
   logic [REG_AW-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] alu_res;
   logic              alu_ovf;
   logic              dec_legal;

   logic [5:0]        fld_op;
   logic [REG_AW-1:0] fld_rs;
   logic [REG_AW-1:0] fld_rt;
   logic [REG_AW-1:0] fld_rd;
   logic [4:0]        fld_shamt;
   logic [5:0]        fld_funct;

   assign fld_op    = inst_p0[OP_MSB:OP_LSB];
   assign fld_rs    = inst_p0[RS_MSB:RS_LSB];
   assign fld_rt    = inst_p0[RT_MSB:RT_LSB];
   assign fld_rd    = inst_p0[RD_MSB:RD_LSB];
   assign fld_shamt = inst_p0[SH_MSB:SH_LSB];
   assign fld_funct = inst_p0[FN_MSB:FN_LSB];

   assign dec_legal  = (fld_op == 6'd0) && funct_legal(fld_funct);
   assign inst_ready = (state == S_IDLE);
   assign wb_en      = (state == S_WB);

   function automatic logic [DATA_W-1:0] alu_calc(
      input logic [5:0]        fn,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [4:0]        sh
   );
      logic [DATA_W-1:0] r;
      r = '0;
      case (fn)
         F_ADD, F_ADDU: r = a + b;
         F_SUB, F_SUBU: r = a - b;
         F_AND:         r = a & b;
         F_OR:          r = a | b;
         F_XOR:         r = a ^ b;
         F_NOR:         r = ~(a | b);
         F_SLT:         r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         F_SLTU:        r = {{(DATA_W-1){1'b0}}, (a < b)};
         F_SLL:         r = b << sh;
         F_SRL:         r = b >> sh;
         F_SRA:         r = $signed(b) >>> sh;
         F_SLLV:        r = b << a[4:0];
         F_SRLV:        r = b >> a[4:0];
         F_SRAV:        r = $signed(b) >>> a[4:0];
         default:       r = '0;
      endcase
      return r;
   endfunction

   // Only the trapping add/sub report overflow; the unsigned forms wrap silently.
   function automatic logic ovf_calc(
      input logic [5:0]        fn,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] r
   );
      case (fn)
         F_ADD:   return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         F_SUB:   return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      alu_res = alu_calc(fld_funct, op_a_p1, op_b_p1, fld_shamt);
      alu_ovf = ovf_calc(fld_funct, op_a_p1, op_b_p1, alu_res);
   end

   // Debug writes and write-back never compete: one is IDLE-only, the other WB-only.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (!rst) begin
         if ((state == S_IDLE) && dbg_we) begin
            rf_we    = 1'b1;
            rf_waddr = dbg_waddr;
            rf_wdata = dbg_wdata;
         end else if ((state == S_WB) && !of) begin
            rf_we    = 1'b1;
            rf_waddr = wb_addr;
            rf_wdata = wb_data;
         end
      end
   end

   regfile #(
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_regfile (
      .clk       (clk),
      .rst       (rst),
      .we        (rf_we),
      .waddr     (rf_waddr),
      .wdata     (rf_wdata),
      .raddr_a   (fld_rs),
      .raddr_b   (fld_rt),
      .dbg_raddr (dbg_raddr),
      .rdata_a   (rf_rdata_a),
      .rdata_b   (rf_rdata_b),
      .dbg_rdata (dbg_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (inst_valid) state_next = S_DECODE;
         S_DECODE: state_next = dec_legal ? S_EXEC : S_IDLE;
         S_EXEC:   state_next = S_WB;
         S_WB:     state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Stage p0: instruction capture on accept
   always_ff @(posedge clk) begin
      if ((state == S_IDLE) && inst_valid) begin
         inst_p0 <= inst_code;
      end
   end

   // Stage p1: operand fetch in DECODE
   always_ff @(posedge clk) begin
      if (state == S_DECODE) begin
         op_a_p1 <= rf_rdata_a;
         op_b_p1 <= rf_rdata_b;
      end
   end

   // Stage p2: result/flag capture in EXEC, retirement in WB
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_addr <= '0;
         wb_data <= '0;
         zf      <= 1'b0;
         of      <= 1'b0;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         case (state)
            S_DECODE: begin
               if (!dec_legal) begin
                  illegal <= 1'b1;
               end
            end
            S_EXEC: begin
               wb_addr <= fld_rd;
               wb_data <= alu_res;
               zf      <= (alu_res == '0);
               of      <= alu_ovf;
            end
            S_WB: begin
               retired <= retired + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_r_exec_stage.sv
// Self-checking bench for r_exec_stage: directed cases plus randomized
// instruction streams compared against an arithmetic reference model.
module tb_r_exec_stage;
   import r_exec_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_code;
   logic        inst_valid;
   logic        inst_ready;
   logic        dbg_we;
   logic [4:0]  dbg_waddr;
   logic [31:0] dbg_wdata;
   logic [4:0]  dbg_raddr;
   logic [31:0] dbg_rdata;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        zf;
   logic        of;
   logic        illegal;
   logic [15:0] retired;

   always #5 clk = ~clk;

   r_exec_stage #(.CLEAR_ON_RST(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_code  (inst_code),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .dbg_we     (dbg_we),
      .dbg_waddr  (dbg_waddr),
      .dbg_wdata  (dbg_wdata),
      .dbg_raddr  (dbg_raddr),
      .dbg_rdata  (dbg_rdata),
      .wb_en      (wb_en),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .zf         (zf),
      .of         (of),
      .illegal    (illegal),
      .retired    (retired)
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_rf [32];
   int          m_retired;
   logic        m_illegal;

   localparam logic [5:0] FUNCTS [16] = '{F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
      F_XOR, F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc(input int rs, input int rt, input int rd,
                                       input int sh, input logic [5:0] fn);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
   endfunction

   // Reference semantics straight from the instruction-set description.
   function automatic void model(input logic [31:0] inst, input logic [31:0] a,
                                 input logic [31:0] b, output logic legal,
                                 output logic [31:0] res, output logic ovf);
      logic [5:0] fn;
      int         sh;
      int         sa;
      int         sb;
      longint     s;
      fn  = inst[5:0];
      sh  = int'(inst[10:6]);
      sa  = a;
      sb  = b;
      res = '0;
      ovf = 1'b0;
      legal = (inst[31:26] == 6'd0) && (fn inside {F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND,
               F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV});
      case (fn)
         F_ADD:  begin s = longint'(sa) + longint'(sb); res = s[31:0];
                       ovf = (s != longint'(int'(s[31:0]))); end
         F_SUB:  begin s = longint'(sa) - longint'(sb); res = s[31:0];
                       ovf = (s != longint'(int'(s[31:0]))); end
         F_ADDU: res = a + b;
         F_SUBU: res = a - b;
         F_AND:  res = a & b;
         F_OR:   res = a | b;
         F_XOR:  res = a ^ b;
         F_NOR:  res = ~(a | b);
         F_SLT:  res = (sa < sb) ? 32'd1 : 32'd0;
         F_SLTU: res = (a < b) ? 32'd1 : 32'd0;
         F_SLL:  res = b << sh;
         F_SRL:  res = b >> sh;
         F_SRA:  res = sb >>> sh;
         F_SLLV: res = b << (a % 32);
         F_SRLV: res = b >> (a % 32);
         F_SRAV: res = sb >>> (a % 32);
         default: res = '0;
      endcase
   endfunction

   task automatic check_rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      dbg_raddr = a;
      @(negedge clk);
      check(tag, dbg_rdata, exp);
   endtask

   task automatic dbg_write(input logic [4:0] a, input logic [31:0] d);
      dbg_we = 1'b1; dbg_waddr = a; dbg_wdata = d;
      tick();
      dbg_we = 1'b0;
      if (a != 5'd0) m_rf[a] = d;
   endtask

   task automatic issue(input string tag, input logic [31:0] inst, input bit noise,
                        input bit dbg_same, input logic [4:0] da, input logic [31:0] dd);
      logic        legal;
      logic        ovf;
      logic [31:0] res;
      logic [4:0]  rd;
      int          n;
      n = 0;
      while (!inst_ready && n < 20) begin tick(); n++; end
      check({tag, "_ready"}, 32'(inst_ready), 32'd1);
      if (dbg_same && da != 5'd0) m_rf[da] = dd;
      rd = inst[15:11];
      model(inst, m_rf[inst[25:21]], m_rf[inst[20:16]], legal, res, ovf);
      inst_code = inst; inst_valid = 1'b1;
      dbg_we = dbg_same; dbg_waddr = da; dbg_wdata = dd;
      tick();
      // DECODE: stray handshakes must be ignored
      dbg_we = noise; dbg_waddr = 5'($urandom); dbg_wdata = $urandom;
      inst_valid = noise; inst_code = $urandom;
      check({tag, "_dec_rdy"}, 32'(inst_ready), 32'd0);
      tick();
      dbg_we = 1'b0; inst_valid = 1'b0;
      if (!legal) begin
         m_illegal = 1'b1;
         check({tag, "_ill"}, 32'(illegal), 32'd1);
         check({tag, "_ill_rdy"}, 32'(inst_ready), 32'd1);
         check({tag, "_ill_wben"}, 32'(wb_en), 32'd0);
         check({tag, "_ill_ret"}, 32'(retired), 32'(m_retired % 65536));
         return;
      end
      dbg_we = noise; dbg_waddr = rd; dbg_wdata = $urandom; inst_valid = noise;
      check({tag, "_ex_wben"}, 32'(wb_en), 32'd0);
      tick();
      check({tag, "_wben"}, 32'(wb_en), 32'd1);
      check({tag, "_wbaddr"}, 32'(wb_addr), 32'(rd));
      check({tag, "_wbdata"}, wb_data, res);
      check({tag, "_zf"}, 32'(zf), 32'(res == 32'd0));
      check({tag, "_of"}, 32'(of), 32'(ovf));
      tick();
      dbg_we = 1'b0; inst_valid = 1'b0;
      if (rd != 5'd0 && !ovf) m_rf[rd] = res;
      m_retired++;
      check({tag, "_ret"}, 32'(retired), 32'(m_retired % 65536));
      check({tag, "_rdy"}, 32'(inst_ready), 32'd1);
      check({tag, "_illst"}, 32'(illegal), 32'(m_illegal));
      check_rd({tag, "_rf"}, rd, m_rf[rd]);
   endtask

   task automatic run(input string tag, input logic [31:0] inst);
      issue(tag, inst, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_retired = 0;
      m_illegal = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rdy"},   32'(inst_ready), 32'd1);
      check({tag, "_wben"},  32'(wb_en), 32'd0);
      check({tag, "_wbadr"}, 32'(wb_addr), 32'd0);
      check({tag, "_wbdat"}, wb_data, 32'd0);
      check({tag, "_zf"},    32'(zf), 32'd0);
      check({tag, "_of"},    32'(of), 32'd0);
      check({tag, "_ill"},   32'(illegal), 32'd0);
      check({tag, "_ret"},   32'(retired), 32'd0);
   endtask

   // Abort an instruction by asserting rst while the FSM sits in the given stage (2=EXEC, 3=WB).
   task automatic reset_in_stage(input string tag, input logic [31:0] inst, input int stage);
      inst_code = inst; inst_valid = 1'b1;
      tick();
      inst_valid = 1'b0;
      for (int i = 1; i < stage; i++) tick();
      check({tag, "_inwb"}, 32'(wb_en), 32'(stage == 3));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      check_reset_outputs(tag);
      check_rd({tag, "_r3"}, 5'd3, 32'd0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 3))
         0: return 32'($urandom_range(0, 15));
         1: case ($urandom_range(0, 4))
               0: return 32'h0000_0000;
               1: return 32'h0000_0001;
               2: return 32'h7FFF_FFFF;
               3: return 32'h8000_0000;
               default: return 32'hFFFF_FFFF;
            endcase
         default: return $urandom;
      endcase
   endfunction

   function automatic logic [31:0] rand_inst();
      int k;
      k = $urandom_range(0, 19);
      if (k == 0) return {6'($urandom_range(1, 63)), 26'($urandom)};
      if (k == 1) begin
         case ($urandom_range(0, 3))
            0: return {6'd0, 20'($urandom), 6'h01};
            1: return {6'd0, 20'($urandom), 6'h05};
            2: return {6'd0, 20'($urandom), 6'h08};
            default: return {6'd0, 20'($urandom), 6'h3F};
         endcase
      end
      return enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), FUNCTS[$urandom_range(0, 15)]);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      rst = 1'b1; inst_code = '0; inst_valid = 1'b0;
      dbg_we = 1'b0; dbg_waddr = '0; dbg_wdata = '0; dbg_raddr = '0;
      model_reset();
      tick(); tick();
      rst = 1'b0;
      check_reset_outputs("rst");
      check_rd("rst_r1", 5'd1, 32'd0);
      check_rd("rst_r31", 5'd31, 32'd0);

      dbg_write(5'd1, 32'd5);
      dbg_write(5'd2, 32'd7);
      run("add", 32'h0022_1820);
      check_rd("add_r3", 5'd3, 32'd12);

      dbg_write(5'd1, 32'h7FFF_FFFF);
      dbg_write(5'd2, 32'd1);
      run("add_ovf", enc(1, 2, 3, 0, F_ADD));
      check_rd("add_ovf_r3", 5'd3, 32'd12);
      run("addu", enc(1, 2, 3, 0, F_ADDU));
      check_rd("addu_r3", 5'd3, 32'h8000_0000);

      dbg_write(5'd1, 32'hFFFF_FFFF);
      run("slt", enc(1, 2, 4, 0, F_SLT));
      check_rd("slt_r4", 5'd4, 32'd1);
      run("sltu", enc(1, 2, 4, 0, F_SLTU));
      check_rd("sltu_r4", 5'd4, 32'd0);
      run("sra", enc(0, 1, 5, 4, F_SRA));
      check_rd("sra_r5", 5'd5, 32'hFFFF_FFFF);
      run("srl", enc(0, 1, 5, 4, F_SRL));
      check_rd("srl_r5", 5'd5, 32'h0FFF_FFFF);

      r0 = m_retired;
      run("lw_ill", 32'h8C01_0000);
      check("ill_ret_same", 32'(retired), 32'(r0));

      run("add_r0", enc(1, 2, 0, 0, F_ADD));
      check_rd("r0_wb", 5'd0, 32'd0);
      dbg_write(5'd0, 32'hDEAD_BEEF);
      check_rd("r0_dbg", 5'd0, 32'd0);

      r0 = m_retired;
      run("or6", enc(1, 0, 6, 0, F_OR));
      run("and7", enc(6, 6, 7, 0, F_AND));
      check_rd("b2b_r7", 5'd7, 32'hFFFF_FFFF);
      check("b2b_ret", 32'(retired), 32'((r0 + 2) % 65536));

      issue("dbgacc", enc(8, 1, 9, 0, F_ADDU), 1'b0, 1'b1, 5'd8, 32'h100);
      check_rd("dbgacc_r9", 5'd9, 32'h0000_00FF);

      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 3) == 0) dbg_write(5'($urandom), rand_val());
         issue($sformatf("rnd%0d", i), rand_inst(), 1'($urandom), ($urandom_range(0, 5) == 0),
               5'($urandom), rand_val());
      end

      dbg_write(5'd1, 32'd5);
      dbg_write(5'd2, 32'd3);
      dbg_write(5'd3, 32'h55);
      reset_in_stage("rst_ex", enc(1, 2, 3, 0, F_SUB), 2);
      dbg_write(5'd1, 32'd9);
      dbg_write(5'd2, 32'd4);
      reset_in_stage("rst_wb", enc(1, 2, 3, 0, F_SUB), 3);

      dbg_write(5'd1, 32'd9);
      dbg_write(5'd2, 32'd4);
      run("post_rst", enc(1, 2, 3, 0, F_SUB));
      check_rd("post_rst_r3", 5'd3, 32'd5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
